// File: rtl/reg_execute_skid.sv
// Decode->execute pipeline register with a 2-entry skid buffer.
// in_ready comes straight from a flop, so execute back-pressure (out_ready)
// never reaches decode combinationally. A flush drops everything held and
// presents a NOP bubble on the next cycle.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_EMPTY | nothing held, q_opcode shows NOP
// S_ONE   | main entry drives q_*, skid entry free (in_ready=1)
// S_FULL  | main drives q_*, skid holds the next instr (in_ready=0)
module reg_execute_skid #(
  parameter int unsigned      OPCODE_W   = 5,
  parameter int unsigned      SCALAR_W   = 32,
  parameter int unsigned      IMM_W      = 8,
  parameter int unsigned      VEC_LANES  = 8,
  parameter int unsigned      LANE_W     = 8,
  parameter int unsigned      WB_W       = 3,
  parameter logic [OPCODE_W-1:0] NOP_OPCODE = 5'b10100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OPCODE_W-1:0]           d_opcode,
  input  logic [SCALAR_W-1:0]           d_reg1_data,
  input  logic [SCALAR_W-1:0]           d_reg2_data,
  input  logic [IMM_W-1:0]              d_immediate,
  input  logic [VEC_LANES*LANE_W-1:0]   d_vec1_data,
  input  logic [VEC_LANES*LANE_W-1:0]   d_vec2_data,
  input  logic [WB_W-1:0]               d_wb_register,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OPCODE_W-1:0]           q_opcode,
  output logic [SCALAR_W-1:0]           q_reg1_data,
  output logic [SCALAR_W-1:0]           q_reg2_data,
  output logic [IMM_W-1:0]              q_immediate,
  output logic [VEC_LANES*LANE_W-1:0]   q_vec1_data,
  output logic [VEC_LANES*LANE_W-1:0]   q_vec2_data,
  output logic [WB_W-1:0]               q_wb_register,
  output logic                          skid_full
);

  localparam int unsigned VEC_W   = VEC_LANES * LANE_W;
  localparam int unsigned INSTR_W = OPCODE_W + 2 * SCALAR_W + IMM_W + 2 * VEC_W + WB_W;

  // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   main_q, main_d;
  logic [INSTR_W-1:0]   skid_q, skid_d;
  logic [INSTR_W-1:0]   d_instr;
  logic [OPCODE_W-1:0]  main_opcode;
  logic                 accept;
  logic                 fire;

  assign d_instr = {d_opcode, d_reg1_data, d_reg2_data, d_immediate,
                    d_vec1_data, d_vec2_data, d_wb_register};

  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];
  assign skid_full = state_q[0];

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  assign {main_opcode, q_reg1_data, q_reg2_data, q_immediate,
          q_vec1_data, q_vec2_data, q_wb_register} = main_q;

  // The opcode alone is masked to NOP while invalid; other fields keep their last value.
  assign q_opcode = out_valid ? main_opcode : NOP_OPCODE;

  // Next-state and entry-load decisions; flush beats everything except reset.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = d_instr;
          end
        end
        S_ONE: begin
          if (accept && fire) begin
            main_d = d_instr;
          end else if (accept) begin
            state_d = S_FULL;
            skid_d  = d_instr;
          end else if (fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State and both entries; reset invalidates immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifndef SYNTHESIS
  // A held skid entry without a valid main entry would reorder instructions.
  always_ff @(posedge clk) begin
    if (reset) assert (!(state_q[0] && !state_q[1]));
  end
`endif

endmodule
